// File: rtl/store_memory_encoder_if.sv
// +----------------------------------------------------------------------------+
// | store_memory_encoder_if : store request and memory write-port bundle         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface store_memory_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;

  // Requester/memory side of the bundle.
  modport master (
    output req_valid, req_type, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
  );

  // Encoder side of the bundle.
  modport slave (
    input  req_valid, req_type, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
  );
endinterface

`default_nettype wire

// File: rtl/store_memory_encoder.sv
// +----------------------------------------------------------------------------+
// | store_memory_encoder : store lane encoder and write sequencer              |
// | Optional macro STORE_MISALIGNED_EN enables split boundary-crossing stores. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module store_memory_encoder (
  input  logic                         clk,
  input  logic                         rst_n,
  store_memory_encoder_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_done;
  logic        r_err;

  logic [1:0]  w_k;
  logic [3:0]  w_mask;
  logic        w_type_ok;
  logic        w_permit;
  logic        w_accept;

  assign w_k      = bus.req_addr[1:0];
  assign w_accept = bus.req_valid && (r_state == IDLE);

  always_comb begin
    w_mask    = 4'b0000;
    w_type_ok = 1'b1;
    case (bus.req_type)
      3'd0:    w_mask = 4'b0001;
      3'd1:    w_mask = 4'b0011;
      3'd2:    w_mask = 4'b1111;
      default: w_type_ok = 1'b0;
    endcase
  end

`ifdef STORE_MISALIGNED_EN
  logic [63:0] w_lane_data;
  logic [7:0]  w_lane_strb;
  logic [31:0] r_hi_data;
  logic [3:0]  r_hi_strb;

  // Upper half of the lane image spills into the next word.
  assign w_lane_data = {32'b0, bus.req_data} << {w_k, 3'b000};
  assign w_lane_strb = {4'b0000, w_mask} << w_k;
  assign w_permit    = w_type_ok;
`else
  logic [31:0] w_lane_data;
  logic [3:0]  w_lane_strb;

  assign w_lane_data = bus.req_data << {w_k, 3'b000};
  assign w_lane_strb = w_mask << w_k;
  // Only naturally aligned halfwords and words are legal here.
  assign w_permit    = w_type_ok &&
                       !((bus.req_type == 3'd1 && w_k[0]) ||
                         (bus.req_type == 3'd2 && w_k != 2'b00));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef STORE_MISALIGNED_EN
      r_hi_data   <= 32'd0;
      r_hi_strb   <= 4'd0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_permit) begin
              r_state     <= BEAT1;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
              r_mem_wdata <= w_lane_data[31:0];
              r_mem_wstrb <= w_lane_strb[3:0];
`ifdef STORE_MISALIGNED_EN
              r_hi_data   <= w_lane_data[63:32];
              r_hi_strb   <= w_lane_strb[7:4];
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (bus.mem_ready) begin
`ifdef STORE_MISALIGNED_EN
            if (r_hi_strb != 4'd0) begin
              r_state     <= BEAT2;
              r_mem_addr  <= r_mem_addr + 32'd4;
              r_mem_wdata <= r_hi_data;
              r_mem_wstrb <= r_hi_strb;
            end else
`endif
            begin
              r_state     <= IDLE;
              r_mem_valid <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
`ifdef STORE_MISALIGNED_EN
        BEAT2: begin
          if (bus.mem_ready) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_store_memory_encoder.sv
// +----------------------------------------------------------------------------+
// | tb_store_memory_encoder : directed + random bench with byte-level model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_store_memory_encoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_memory_encoder_if bus();

  store_memory_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model results: list of expected beats for one store.
  bit          m_rej;
  int          m_nb;
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_strb [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Walks the store byte by byte and drops each byte into the word it lands in.
  task automatic run_model(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    int          size;
    int          b;
    int          lane;
    logic [31:0] base;
    logic [31:0] ba;
    size  = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : (t == 3'd2) ? 4 : 0;
    m_rej = 1'b0;
    m_nb  = 0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 32'd0;
      m_data[i] = 32'd0;
      m_strb[i] = 4'd0;
    end
    base = a & 32'hFFFF_FFFC;
    if (size == 0) m_rej = 1'b1;
`ifndef STORE_MISALIGNED_EN
    else if ((a % size) != 0) m_rej = 1'b1;
`endif
    if (!m_rej) begin
      for (int i = 0; i < size; i++) begin
        ba   = a + i;
        b    = ((ba & 32'hFFFF_FFFC) == base) ? 0 : 1;
        lane = ba % 4;
        m_data[b][8*lane +: 8] = d[8*i +: 8];
        m_strb[b][lane]        = 1'b1;
        m_addr[b]              = base + 32'(4 * b);
        if (b + 1 > m_nb) m_nb = b + 1;
      end
    end
  endtask

  // Issue a store at a negedge; each beat is stalled for 'stall' cycles.
  task automatic do_store(input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input int stall);
    logic [31:0] mask;
    run_model(t, a, d);
    check_val("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_data  = d;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    if (m_rej) begin
      check_val("err_pulse", 32'(bus.err), 32'd1);
      check_val("rej_mem_valid", 32'(bus.mem_valid), 32'd0);
      check_val("rej_done", 32'(bus.done), 32'd0);
    end else begin
      for (int b = 0; b < m_nb; b++) begin
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{m_strb[b][i]}};
        for (int c = 0; c <= stall; c++) begin
          check_val("beat_valid", 32'(bus.mem_valid), 32'd1);
          check_val("beat_addr", bus.mem_addr, m_addr[b]);
          check_val("beat_strb", 32'(bus.mem_wstrb), 32'(m_strb[b]));
          check_val("beat_data", bus.mem_wdata & mask, m_data[b] & mask);
          check_val("busy_req_ready", 32'(bus.req_ready), 32'd0);
          check_val("busy_done", 32'(bus.done), 32'd0);
          if (c == stall) bus.mem_ready = 1'b1;
          @(negedge clk);
        end
        bus.mem_ready = 1'b0;
      end
      check_val("done_pulse", 32'(bus.done), 32'd1);
      check_val("done_mem_valid", 32'(bus.mem_valid), 32'd0);
      check_val("done_req_ready", 32'(bus.req_ready), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check_val({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'd0);
    check_val({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
    check_val({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    check_val({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    check_val({tag, "_done"},      32'(bus.done),      32'd0);
    check_val({tag, "_err"},       32'(bus.err),       32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  t;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_type  = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_data  = 32'd0;
    bus.mem_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_store(3'd0, 32'h0000_1003, 32'h0000_00A5, 0);
    do_store(3'd1, 32'h0000_2002, 32'h0000_BEEF, 0);
    do_store(3'd2, 32'h0000_3001, 32'h1122_3344, 0);
    do_store(3'd2, 32'h0000_4000, 32'hCAFE_F00D, 3);
    do_store(3'd5, 32'h0000_0100, 32'h1234_5678, 0);
    do_store(3'd2, 32'h0000_5002, 32'hDEAD_BEEF, 0);
    do_store(3'd1, 32'hFFFF_FFFF, 32'h0000_9A7B, 0);
    do_store(3'd1, 32'h0000_7001, 32'h0000_5566, 1);

    for (int n = 0; n < 60; n++) begin
      t = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      do_store(t, a, $urandom, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Reset in the middle of a store: outputs drop at once and no done follows.
    bus.req_valid = 1'b1;
    bus.req_type  = 3'd2;
`ifdef STORE_MISALIGNED_EN
    bus.req_addr  = 32'h0000_3001;
`else
    bus.req_addr  = 32'h0000_6000;
`endif
    bus.req_data  = 32'h1122_3344;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("mid_valid", 32'(bus.mem_valid), 32'd1);
`ifdef STORE_MISALIGNED_EN
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check_val("mid_beat2_addr", bus.mem_addr, 32'h0000_3004);
`endif
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("postrst_done", 32'(bus.done), 32'd0);
      check_val("postrst_valid", 32'(bus.mem_valid), 32'd0);
    end
    do_store(3'd0, 32'h0000_0000, 32'h0000_005A, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
